// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
//   Occupancy counter and entry-barrier sequencer. Consumes one-cycle entry (E)
//   and exit (S) pulses from the car-direction detector, tracks the number of
//   cars inside and sequences the entry barrier (IDLE -> OPEN -> CLOSING).
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   req        in   entry request button (level, synchronous to clk)
//   E          in   entry pulse from detector (one cycle)
//   S          in   exit pulse from detector (one cycle)
//   count      out  cars currently inside
//   full       out  count == CAPACITY
//   empty      out  count == 0
//   gate_open  out  barrier command, high while in OPEN
//   denied     out  pulse: request refused because lot is full
//   timeout    out  pulse: gate closed without an entry
//   tailgate   out  pulse: E seen while gate not OPEN
//   err_ovf    out  pulse: E seen while count == CAPACITY
//   err_udf    out  pulse: S seen while count == 0
// -----------------------------------------------------------------------------
module parking_gate_ctrl #(
   parameter int CAPACITY     = 16,
   parameter int CNT_W        = 5,
   parameter int OPEN_CYCLES  = 100,
   parameter int CLOSE_CYCLES = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             E,
   input  logic             S,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             gate_open,
   output logic             denied,
   output logic             timeout,
   output logic             tailgate,
   output logic             err_ovf,
   output logic             err_udf
);

   localparam int TMR_MAX = (OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_OPEN    = 2'd1;
   localparam logic [1:0] ST_CLOSING = 2'd2;

   localparam logic [CNT_W-1:0] CAP        = CNT_W'(CAPACITY);
   localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0] CLOSE_LOAD = TMR_W'(CLOSE_CYCLES - 1);

   logic [1:0]       state, state_d;
   logic [TMR_W-1:0] timer, timer_d;
   logic [CNT_W-1:0] count_d;
   logic             req_q, req_rise;
   logic             denied_d, timeout_d, tailgate_d, ovf_d, udf_d;

   assign req_rise  = req & ~req_q;
   assign full      = (count == CAP);
   assign empty     = (count == '0);
   assign gate_open = (state == ST_OPEN);

   // Barrier sequencer. The grant check uses the registered count, so an
   // E/S in the same cycle as the request does not affect the decision.
   always_comb begin
      state_d   = state;
      timer_d   = timer;
      denied_d  = 1'b0;
      timeout_d = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_rise) begin
               if (full) begin
                  denied_d = 1'b1;
               end else begin
                  state_d = ST_OPEN;
                  timer_d = OPEN_LOAD;
               end
            end
         end
         ST_OPEN: begin
            // An entry on the last open cycle wins over the timeout.
            if (E) begin
               state_d = ST_CLOSING;
               timer_d = CLOSE_LOAD;
            end else if (timer == '0) begin
               timeout_d = 1'b1;
               state_d   = ST_CLOSING;
               timer_d   = CLOSE_LOAD;
            end else begin
               timer_d = timer - TMR_W'(1);
            end
         end
         ST_CLOSING: begin
            if (timer == '0) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = timer - TMR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // Occupancy counter. Simultaneous E and S cancel with no error flagged.
   always_comb begin
      count_d    = count;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
      tailgate_d = E & (state != ST_OPEN);
      if (E && !S) begin
         if (full) ovf_d   = 1'b1;
         else      count_d = count + CNT_W'(1);
      end else if (S && !E) begin
         if (empty) udf_d   = 1'b1;
         else       count_d = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         timer    <= '0;
         req_q    <= 1'b0;
         count    <= '0;
         denied   <= 1'b0;
         timeout  <= 1'b0;
         tailgate <= 1'b0;
         err_ovf  <= 1'b0;
         err_udf  <= 1'b0;
      end else begin
         state    <= state_d;
         timer    <= timer_d;
         req_q    <= req;
         count    <= count_d;
         denied   <= denied_d;
         timeout  <= timeout_d;
         tailgate <= tailgate_d;
         err_ovf  <= ovf_d;
         err_udf  <= udf_d;
      end
   end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_ctrl
//   Directed self-checking bench for parking_gate_ctrl with CAPACITY=3,
//   OPEN_CYCLES=8, CLOSE_CYCLES=4. Expected outputs are queued as each
//   stimulus step is driven and compared after the following clock edge.
// -----------------------------------------------------------------------------
module tb_parking_gate_ctrl;

   localparam int CAP     = 3;
   localparam int CW      = 3;
   localparam int OPEN_C  = 8;
   localparam int CLOSE_C = 4;

   logic          clk = 1'b0;
   logic          rst, req, E, S;
   logic [CW-1:0] count;
   logic          full, empty, gate_open, denied, timeout, tailgate, err_ovf, err_udf;

   parking_gate_ctrl #(
      .CAPACITY(CAP),
      .CNT_W(CW),
      .OPEN_CYCLES(OPEN_C),
      .CLOSE_CYCLES(CLOSE_C)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .E(E), .S(S),
      .count(count), .full(full), .empty(empty), .gate_open(gate_open),
      .denied(denied), .timeout(timeout), .tailgate(tailgate),
      .err_ovf(err_ovf), .err_udf(err_udf)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   string sig_name [9] = '{"count", "full", "empty", "gate_open", "denied",
                           "timeout", "tailgate", "err_ovf", "err_udf"};

   function automatic logic [31:0] observe(int sig);
      case (sig)
         0:       return 32'(count);
         1:       return 32'(full);
         2:       return 32'(empty);
         3:       return 32'(gate_open);
         4:       return 32'(denied);
         5:       return 32'(timeout);
         6:       return 32'(tailgate);
         7:       return 32'(err_ovf);
         default: return 32'(err_udf);
      endcase
   endfunction

   task automatic push(string tag, int sig, int val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = 32'(val);
      exp_q.push_back(e);
   endtask

   // full/empty expectations derived from the expected count.
   task automatic push_all(string tag, int cnt, int g, int den, int to,
                           int tg, int ovf, int udf);
      push(tag, 0, cnt);
      push(tag, 1, (cnt == CAP) ? 1 : 0);
      push(tag, 2, (cnt == 0) ? 1 : 0);
      push(tag, 3, g);
      push(tag, 4, den);
      push(tag, 5, to);
      push(tag, 6, tg);
      push(tag, 7, ovf);
      push(tag, 8, udf);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         obs = observe(e.sig);
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s.%s observed %0d expected %0d", e.tag, sig_name[e.sig], obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      drain();
   endtask

   // Full barrier cycle: grant, open_ticks cycles open, E, closing, back to IDLE.
   task automatic do_entry(string tag, int cnt, int open_ticks);
      req = 1'b1;
      push_all({tag, "_grant"}, cnt, 1, 0, 0, 0, 0, 0);
      tick();
      req = 1'b0;
      repeat (open_ticks - 1) begin
         push_all({tag, "_open"}, cnt, 1, 0, 0, 0, 0, 0);
         tick();
      end
      E = 1'b1;
      push_all({tag, "_entry"}, cnt + 1, 0, 0, 0, 0, 0, 0);
      tick();
      E = 1'b0;
      repeat (CLOSE_C - 1) begin
         push_all({tag, "_closing"}, cnt + 1, 0, 0, 0, 0, 0, 0);
         tick();
      end
      push_all({tag, "_idle"}, cnt + 1, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      req = 1'b0;
      E   = 1'b0;
      S   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      push_all("reset", 0, 0, 0, 0, 0, 0, 0);
      drain();
      rst = 1'b0;

      // Normal entry: E on the 4th open cycle, count 0 -> 1.
      do_entry("entry1", 0, 4);

      // Timeout: gate open exactly OPEN_C cycles, timeout on first CLOSING cycle.
      req = 1'b1;
      push_all("to_grant", 1, 1, 0, 0, 0, 0, 0);
      tick();
      req = 1'b0;
      repeat (OPEN_C - 1) begin
         push_all("to_open", 1, 1, 0, 0, 0, 0, 0);
         tick();
      end
      push_all("to_expire", 1, 0, 0, 1, 0, 0, 0);
      tick();

      // Request rises during CLOSING and is held: never reopens.
      req = 1'b1;
      repeat (6) begin
         push_all("hold_req", 1, 0, 0, 0, 0, 0, 0);
         tick();
      end
      req = 1'b0;
      push_all("hold_release", 1, 0, 0, 0, 0, 0, 0);
      tick();

      // E on the timer==0 cycle counts as an entry with no timeout.
      do_entry("entry_last", 1, OPEN_C);
      do_entry("entry3", 2, 2);

      // Lot full: request denied, gate stays shut.
      req = 1'b1;
      push_all("deny", 3, 0, 1, 0, 0, 0, 0);
      tick();
      req = 1'b0;
      push_all("deny_after", 3, 0, 0, 0, 0, 0, 0);
      tick();

      // E at capacity outside OPEN: overflow and tailgate, count held.
      E = 1'b1;
      push_all("ovf", 3, 0, 0, 0, 1, 1, 0);
      tick();
      E = 1'b0;
      push_all("ovf_after", 3, 0, 0, 0, 0, 0, 0);
      tick();

      // Exit frees a space; next request is granted.
      S = 1'b1;
      push_all("exit", 2, 0, 0, 0, 0, 0, 0);
      tick();
      S = 1'b0;
      req = 1'b1;
      push_all("regrant", 2, 1, 0, 0, 0, 0, 0);
      tick();
      req = 1'b0;
      push_all("regrant_open", 2, 1, 0, 0, 0, 0, 0);
      tick();

      // Asynchronous reset in the middle of a cycle while OPEN.
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      push_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
      drain();
      @(negedge clk);
      rst = 1'b0;
      push_all("post_rst", 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Underflow at count 0.
      S = 1'b1;
      push_all("udf", 0, 0, 0, 0, 0, 0, 1);
      tick();
      S = 1'b0;
      push_all("udf_after", 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Grant right after reset proves IDLE; then E and S together at count 0.
      req = 1'b1;
      push_all("es_grant", 0, 1, 0, 0, 0, 0, 0);
      tick();
      req = 1'b0;
      E = 1'b1;
      S = 1'b1;
      push_all("es_both", 0, 0, 0, 0, 0, 0, 0);
      tick();
      E = 1'b0;
      S = 1'b0;
      push_all("es_after", 0, 0, 0, 0, 0, 0, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
